t07_spitft_sched: RTL and testbench
===================================

# t07_spitft_sched

Transaction scheduler in front of `t07_spitft`, the SPI-to-TFT master. It owns the master's `in`/`wi`/`delay` inputs and plays a fixed power-on init sequence from a small ROM. After that it round-robin arbitrates single-word SPI transactions between a CPU port and a display-refresh port. It enforces an inter-transaction gap and a watchdog timeout, and returns `miso_out` read data to whichever requester owned the transaction.

## Interface
Parameters:
- `RESET_WAIT`, 100: cycles spent in post-reset settle before the first init word.
- `GAP_CYCLES`, 5: cycles `spi_delay` is held high after each completed or aborted transaction.
- `TIMEOUT`, 1000: cycles a transaction may wait for `spi_ack` before it is aborted.
- `INIT_LEN`, 4: number of init ROM words, valid range 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `nrst`  in  1: asynchronous active-low reset.
- `cpu_req`  in  1: CPU requests a transaction; level.
- `cpu_word`  in  16: word forwarded to `spi_in`; must be stable while `cpu_req` is high and not yet granted.
- `cpu_gnt`  out  1: 1-cycle pulse; `cpu_word` has been latched.
- `cpu_done`  out  1: 1-cycle pulse; CPU transaction finished.
- `cpu_rdata`  out  8: `miso_out` captured at ack; valid while `cpu_done` is high, held until the next CPU completion.
- `disp_req`, `disp_word`, `disp_gnt`, `disp_done`, `disp_rdata`: same widths and semantics as the CPU port.
- `spi_in`  out  16: drives `t07_spitft.in`.
- `spi_wi`  out  1: drives `t07_spitft.wi`.
- `spi_delay`  out  1: drives `t07_spitft.delay`.
- `spi_ack`  in  1: from `t07_spitft.ack`.
- `spi_miso`  in  8: from `t07_spitft.miso_out`.
- `init_done`  out  1: high once the init ROM is exhausted; sticky until reset.
- `err`  out  1: 1-cycle pulse on timeout abort.

## Operation
- Word format is opaque. Words are forwarded unmodified, and `t07_spitft` decodes command, data and read from them.
- FSM states: `RST_WAIT`, `IDLE`, `XFER`, `GAP`.
- `RST_WAIT`: counts `RESET_WAIT` cycles with `spi_delay`=1, then goes to `IDLE`.
- `IDLE` selects a source in this order:
  - If `init_idx < INIT_LEN`: load ROM word `init_idx`, set source=INIT, go to `XFER`.
  - Else if exactly one requester is active: grant it.
  - Else if both are active: grant the one not granted last. `last_gnt` resets to DISP, so the CPU wins the first tie.
  - On any grant: latch the word into `spi_in`, pulse the matching `*_gnt`, update `last_gnt`, go to `XFER`.
- `XFER`:
  - `spi_wi`=1 and `spi_in` is held constant.
  - First cycle with `spi_ack`=1: capture `spi_miso` into the owner's rdata, pulse the owner's `*_done` (the INIT source has none; increment `init_idx` instead), go to `GAP`.
  - Timeout counter reaching `TIMEOUT`: pulse `err`, pulse the owner's `*_done` with rdata unchanged. For INIT, still increment `init_idx`. Go to `GAP`.
- `GAP`: `spi_wi`=0 and `spi_delay`=1 for `GAP_CYCLES` cycles, then `IDLE`.
- `init_done` = (`init_idx == INIT_LEN`). With `INIT_LEN`=0 it is high on the first `IDLE` cycle.
- Requests arriving during `RST_WAIT`, init, `XFER` or `GAP` stay pending and are not lost; `req` is a level.
- A requester dropping `req` before its grant is simply never served.

## Timing
- Reset values:
  - State `RST_WAIT`; `spi_delay`=1 (decoded from state).
  - `spi_wi`=0; `spi_in`=0.
  - All `*_gnt`, `*_done`, `err` = 0; both rdata = 0; `init_done`=0.
  - `init_idx`=0, `last_gnt`=DISP, counters = 0.
- Reset mid-transaction: `spi_wi` falls asynchronously; no `*_done` is issued; the init sequence restarts.
- Grant latency: `req` high in `IDLE` at edge N means `*_gnt` and `spi_wi` are high after edge N+1.
- Completion: `spi_ack` high at edge M means `*_done` is high and `spi_wi` is low after edge M+1.
- A `spi_ack` that arrives on the same edge as the timeout counter reaching `TIMEOUT` counts as success. No `err` is raised.
- Minimum spacing between the fall of `spi_wi` and its next rise: `GAP_CYCLES`+1 cycles.
- Counters are 16-bit and saturate, with no wrap. Parameters must be below 65535.
- `spi_ack` outside `XFER` is ignored.

## Structure
- Package `t07_spitft_sched_pkg` holds:
  - `state_t` enum;
  - `src_t` enum {SRC_INIT, SRC_CPU, SRC_DISP};
  - init words `INIT_ROM[0:3]` = 16'h0001, 16'h0011, 16'h003A, 16'h0029.
- Sub-module `t07_tft_init_rom`: combinational, 4-bit index in, 16-bit word out. Indexes ≥ `INIT_LEN` return 0.
- The arbiter, FSM and counters stay in the top module.

## Test plan
- Reset, ack returned 3 cycles after each `spi_wi` rise:
  - `spi_delay`=1 for 100 cycles;
  - four init words 0001, 0011, 003A, 0029 in order, each followed by a 5-cycle gap;
  - `init_done` rises after the fourth.
- After init, `cpu_req` with `cpu_word`=16'h801D and ack with `spi_miso`=8'hB3:
  - `cpu_gnt` one cycle after the request, `spi_in`=801D;
  - `cpu_done` with `cpu_rdata`=B3.
- Both requesters held high for 4 transactions: grant order is CPU, DISP, CPU, DISP, and the gap is respected between each.
- Never ack: `err` and `cpu_done` both pulse 1000 cycles into `XFER`; the next request is then served normally.
- `nrst` pulsed low mid-`XFER`:
  - `spi_wi` drops immediately;
  - no done pulse;
  - the init sequence replays from word 0001.
- `disp_req` asserted during `RST_WAIT`: held until `init_done`, then granted with no loss.

Source files
------------

// File: rtl/t07_spitft_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t07_spitft_sched_pkg
// Description : Shared types and init ROM contents for the SPI-TFT scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package t07_spitft_sched_pkg;

    // Scheduler FSM states; spi_wi and spi_delay are decoded from these
    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        IDLE     = 2'd1,
        XFER     = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Owner of the transaction currently in flight
    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_DISP = 2'd2
    } src_t;

    localparam int INIT_ROM_DEPTH = 4;

    // Power-on command words for the panel, played in index order
    localparam logic [15:0] INIT_ROM [0:3] = '{16'h0001, 16'h0011, 16'h003A, 16'h0029};

endpackage
`default_nettype wire

// File: rtl/t07_tft_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : t07_tft_init_rom
// Description : Combinational init word lookup; indexes past INIT_LEN or past
//               the physical ROM depth read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module t07_tft_init_rom
    import t07_spitft_sched_pkg::*;
#(
    parameter int INIT_LEN = 4
) (
    input  logic [3:0]  idx,
    output logic [15:0] word
);

    // Return the ROM word only for indexes inside both the sequence and the table
    always_comb begin
        word = '0;
        if (({28'd0, idx} < INIT_LEN) && (idx < 4'(INIT_ROM_DEPTH))) begin
            word = INIT_ROM[idx[1:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/t07_spitft_sched.sv
`default_nettype none
// ============================================================================
// Module      : t07_spitft_sched
// Description : Transaction scheduler for t07_spitft. Plays the init ROM after
//               reset, then round-robin arbitrates CPU and display requests,
//               with an inter-transaction gap and an ack watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module t07_spitft_sched
    import t07_spitft_sched_pkg::*;
#(
    parameter int RESET_WAIT = 100,
    parameter int GAP_CYCLES = 5,
    parameter int TIMEOUT    = 1000,
    parameter int INIT_LEN   = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_word,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic [7:0]  cpu_rdata,
    input  logic        disp_req,
    input  logic [15:0] disp_word,
    output logic        disp_gnt,
    output logic        disp_done,
    output logic [7:0]  disp_rdata,
    output logic [15:0] spi_in,
    output logic        spi_wi,
    output logic        spi_delay,
    input  logic        spi_ack,
    input  logic [7:0]  spi_miso,
    output logic        init_done,
    output logic        err
);

    localparam logic [15:0] RESET_WAIT_W = 16'(RESET_WAIT);
    localparam logic [15:0] GAP_W        = 16'(GAP_CYCLES);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT);
    localparam logic [3:0]  INIT_LEN_W   = 4'(INIT_LEN);

    state_t      state, next_state;
    src_t        src, last_gnt;
    logic [15:0] cnt, cnt_next, cnt_inc;
    logic [3:0]  init_idx;
    logic [15:0] rom_word;
    logic        init_pending;
    logic        take_init, grant_cpu, grant_disp;
    logic        xfer_ok, xfer_abort;

    t07_tft_init_rom #(
        .INIT_LEN (INIT_LEN)
    ) u_init_rom (
        .idx  (init_idx),
        .word (rom_word)
    );

    assign init_pending = (init_idx < INIT_LEN_W);
    // Saturating increment so a huge parameter can never wrap the counter
    assign cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Master controls decode straight from state so reset drops spi_wi at once
    assign spi_wi    = (state == XFER);
    assign spi_delay = (state == RST_WAIT) || (state == GAP);
    assign init_done = (state != RST_WAIT) && (init_idx == INIT_LEN_W);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, arbitration and counter decisions
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        take_init  = 1'b0;
        grant_cpu  = 1'b0;
        grant_disp = 1'b0;
        xfer_ok    = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            RST_WAIT: begin
                if (cnt_inc >= RESET_WAIT_W) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            IDLE: begin
                cnt_next = '0;
                if (init_pending) begin
                    take_init  = 1'b1;
                    next_state = XFER;
                end else if (cpu_req && (!disp_req || (last_gnt == SRC_DISP))) begin
                    grant_cpu  = 1'b1;
                    next_state = XFER;
                end else if (disp_req) begin
                    grant_disp = 1'b1;
                    next_state = XFER;
                end
            end
            XFER: begin
                // An ack on the timeout edge still wins over the abort
                if (spi_ack) begin
                    xfer_ok    = 1'b1;
                    next_state = GAP;
                    cnt_next   = '0;
                end else if (cnt_inc >= TIMEOUT_W) begin
                    xfer_abort = 1'b1;
                    next_state = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_inc >= GAP_W) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                next_state = RST_WAIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulses, word latch, read-data capture and init progress
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt        <= '0;
            spi_in     <= '0;
            src        <= SRC_INIT;
            last_gnt   <= SRC_DISP;
            init_idx   <= '0;
            cpu_gnt    <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            disp_gnt   <= 1'b0;
            disp_done  <= 1'b0;
            disp_rdata <= '0;
            err        <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            cpu_gnt   <= grant_cpu;
            disp_gnt  <= grant_disp;
            cpu_done  <= 1'b0;
            disp_done <= 1'b0;
            err       <= xfer_abort;
            if (take_init) begin
                spi_in <= rom_word;
                src    <= SRC_INIT;
            end
            if (grant_cpu) begin
                spi_in   <= cpu_word;
                src      <= SRC_CPU;
                last_gnt <= SRC_CPU;
            end
            if (grant_disp) begin
                spi_in   <= disp_word;
                src      <= SRC_DISP;
                last_gnt <= SRC_DISP;
            end
            // Aborted transactions complete too, but leave rdata untouched
            if (xfer_ok || xfer_abort) begin
                case (src)
                    SRC_CPU: begin
                        cpu_done <= 1'b1;
                        if (xfer_ok) cpu_rdata <= spi_miso;
                    end
                    SRC_DISP: begin
                        disp_done <= 1'b1;
                        if (xfer_ok) disp_rdata <= spi_miso;
                    end
                    default: begin
                        init_idx <= init_idx + 4'd1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t07_spitft_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_t07_spitft_sched
// Description : Self-checking bench for t07_spitft_sched with an SPI ack
//               responder and a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t07_spitft_sched;

    localparam int RESET_WAIT = 100;
    localparam int GAP_CYCLES = 5;
    localparam int TIMEOUT    = 1000;
    localparam int INIT_LEN   = 4;
    localparam int ACK_DELAY  = 3;
    localparam int P_CPU      = 0;
    localparam int P_DISP     = 1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cpu_req = 1'b0, disp_req = 1'b0;
    logic [15:0] cpu_word = '0, disp_word = '0;
    logic        cpu_gnt, cpu_done, disp_gnt, disp_done;
    logic [7:0]  cpu_rdata, disp_rdata;
    logic [15:0] spi_in;
    logic        spi_wi, spi_delay, init_done, err;
    logic        spi_ack;
    logic [7:0]  spi_miso;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model state
    int          model_last;
    logic [7:0]  model_cpu_rdata, model_disp_rdata;
    logic [15:0] exp_init [4] = '{16'h0001, 16'h0011, 16'h003A, 16'h0029};

    // Responder controls and log
    bit          ack_en = 1'b1;
    int          fixed_miso = -1;
    logic [7:0]  last_miso = '0;

    // Monitor log
    int          rise_q[$];
    int          fall_q[$];
    logic [15:0] word_q[$];
    int          done_cnt = 0;

    t07_spitft_sched #(
        .RESET_WAIT (RESET_WAIT),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .INIT_LEN   (INIT_LEN)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cpu_req    (cpu_req),
        .cpu_word   (cpu_word),
        .cpu_gnt    (cpu_gnt),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .disp_req   (disp_req),
        .disp_word  (disp_word),
        .disp_gnt   (disp_gnt),
        .disp_done  (disp_done),
        .disp_rdata (disp_rdata),
        .spi_in     (spi_in),
        .spi_wi     (spi_wi),
        .spi_delay  (spi_delay),
        .spi_ack    (spi_ack),
        .spi_miso   (spi_miso),
        .init_done  (init_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack responder: ack ACK_DELAY cycles after each spi_wi rise
    initial begin
        int cd;
        bit prev_wi;
        cd = -1;
        prev_wi = 1'b0;
        spi_ack = 1'b0;
        spi_miso = '0;
        forever begin
            tick();
            spi_ack = 1'b0;
            if (!spi_wi) begin
                cd = -1;
            end else begin
                if (!prev_wi) cd = ACK_DELAY;
                if (ack_en && cd == 0) begin
                    last_miso = (fixed_miso >= 0) ? 8'(fixed_miso) : 8'($urandom);
                    spi_miso  = last_miso;
                    spi_ack   = 1'b1;
                    cd        = -1;
                end else if (cd > 0) begin
                    cd--;
                end
            end
            prev_wi = spi_wi;
        end
    end

    // Transaction monitor: spi_wi edges, latched words, done pulses
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            tick();
            if (spi_wi && !prev) begin
                rise_q.push_back(cyc);
                word_q.push_back(spi_in);
            end
            if (!spi_wi && prev) fall_q.push_back(cyc);
            if (cpu_done || disp_done) done_cnt++;
            prev = spi_wi;
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((spi_wi || spi_delay) && n < 2000) begin
            n++;
            tick();
        end
        n_tests++;
        if (spi_wi !== 1'b0 || spi_delay !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: got wi=%b delay=%b required 0 0", spi_wi, spi_delay);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        cpu_req = 1'b0;
        disp_req = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (spi_wi !== 1'b0 || spi_delay !== 1'b1 || spi_in !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_spi: got wi=%b delay=%b in=%h required 0 1 0000", spi_wi, spi_delay, spi_in);
        end
        n_tests++;
        if ({cpu_gnt, cpu_done, disp_gnt, disp_done, err, init_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b required 000000",
                     {cpu_gnt, cpu_done, disp_gnt, disp_done, err, init_done});
        end
        n_tests++;
        if (cpu_rdata !== 8'h0 || disp_rdata !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h required 00 00", cpu_rdata, disp_rdata);
        end
        model_last = P_DISP;
        model_cpu_rdata = '0;
        model_disp_rdata = '0;
    endtask

    task automatic test_init();
        int n;
        int done_at;
        rise_q.delete();
        fall_q.delete();
        word_q.delete();
        nrst = 1'b1;
        n = 0;
        while (spi_delay === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        n_tests++;
        if (n != RESET_WAIT) begin
            n_fail++;
            $display("FAIL rst_wait_len: got %0d required %0d", n, RESET_WAIT);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 500) begin
            n++;
            tick();
        end
        done_at = cyc;
        n_tests++;
        if (init_done !== 1'b1 || word_q.size() != INIT_LEN) begin
            n_fail++;
            $display("FAIL init_count: got done=%b words=%0d required 1 %0d", init_done, word_q.size(), INIT_LEN);
        end
        for (int i = 0; i < word_q.size() && i < INIT_LEN; i++) begin
            n_tests++;
            if (word_q[i] !== exp_init[i]) begin
                n_fail++;
                $display("FAIL init_word%0d: got %h required %h", i, word_q[i], exp_init[i]);
            end
        end
        for (int i = 1; i < rise_q.size() && i < fall_q.size() + 1; i++) begin
            n_tests++;
            if (rise_q[i] - fall_q[i-1] != GAP_CYCLES + 1) begin
                n_fail++;
                $display("FAIL init_gap%0d: got %0d required %0d", i, rise_q[i] - fall_q[i-1], GAP_CYCLES + 1);
            end
        end
        n_tests++;
        if (fall_q.size() < INIT_LEN || fall_q[INIT_LEN-1] != done_at) begin
            n_fail++;
            $display("FAIL init_done_time: got cycle %0d required last fall (%0d falls)", done_at, fall_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n, got, exp, base;
        cpu_word  = 16'($urandom);
        disp_word = 16'($urandom);
        cpu_req   = 1'b1;
        disp_req  = 1'b1;
        base = rise_q.size();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!cpu_gnt && !disp_gnt && n < 100) begin
                n++;
                tick();
            end
            exp = (model_last == P_CPU) ? P_DISP : P_CPU;
            got = cpu_gnt ? P_CPU : (disp_gnt ? P_DISP : -1);
            n_tests++;
            if (got != exp) begin
                n_fail++;
                $display("FAIL rr_order%0d: got %0d required %0d", k, got, exp);
            end
            n_tests++;
            if (spi_in !== ((exp == P_CPU) ? cpu_word : disp_word) || spi_wi !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_word%0d: got %h wi=%b required %h 1", k, spi_in, spi_wi,
                         (exp == P_CPU) ? cpu_word : disp_word);
            end
            if (got >= 0) model_last = got;
            if (got == P_CPU) cpu_word = 16'($urandom);
            else disp_word = 16'($urandom);
            n = 0;
            while (!cpu_done && !disp_done && n < 100) begin
                n++;
                tick();
            end
            if (got == P_CPU) model_cpu_rdata = last_miso;
            else model_disp_rdata = last_miso;
            n_tests++;
            if ((got == P_CPU && (cpu_done !== 1'b1 || cpu_rdata !== model_cpu_rdata)) ||
                (got != P_CPU && (disp_done !== 1'b1 || disp_rdata !== model_disp_rdata))) begin
                n_fail++;
                $display("FAIL rr_done%0d: got done=%b%b rdata=%h/%h required %h/%h", k, cpu_done, disp_done,
                         cpu_rdata, disp_rdata, model_cpu_rdata, model_disp_rdata);
            end
        end
        cpu_req  = 1'b0;
        disp_req = 1'b0;
        for (int i = base + 1; i < rise_q.size() && i <= fall_q.size(); i++) begin
            n_tests++;
            if (rise_q[i] - fall_q[i-1] != GAP_CYCLES + 1) begin
                n_fail++;
                $display("FAIL rr_gap%0d: got %0d required %0d", i, rise_q[i] - fall_q[i-1], GAP_CYCLES + 1);
            end
        end
    endtask

    task automatic test_cpu_single();
        int n, t0;
        wait_idle();
        fixed_miso = 8'hB3;
        cpu_word = 16'h801D;
        cpu_req = 1'b1;
        t0 = cyc;
        n = 0;
        while (!cpu_gnt && n < 50) begin
            n++;
            tick();
        end
        n_tests++;
        if (cpu_gnt !== 1'b1 || cyc - t0 != 1) begin
            n_fail++;
            $display("FAIL gnt_latency: got gnt=%b after %0d cycles required 1 after 1", cpu_gnt, cyc - t0);
        end
        n_tests++;
        if (spi_in !== 16'h801D || spi_wi !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word: got %h wi=%b required 801d 1", spi_in, spi_wi);
        end
        cpu_req = 1'b0;
        model_last = P_CPU;
        n = 0;
        while (!cpu_done && n < 50) begin
            n++;
            tick();
        end
        model_cpu_rdata = 8'hB3;
        n_tests++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 8'hB3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b rdata=%h err=%b required 1 b3 0", cpu_done, cpu_rdata, err);
        end
        repeat (3) tick();
        n_tests++;
        if (cpu_rdata !== model_cpu_rdata || cpu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h done=%b required %h 0", cpu_rdata, cpu_done, model_cpu_rdata);
        end
        fixed_miso = -1;
    endtask

    task automatic test_timeout();
        int n;
        wait_idle();
        ack_en = 1'b0;
        cpu_word = 16'($urandom);
        cpu_req = 1'b1;
        n = 0;
        while (!cpu_gnt && n < 50) begin
            n++;
            tick();
        end
        cpu_req = 1'b0;
        model_last = P_CPU;
        n = 0;
        while (!err && n < TIMEOUT + 100) begin
            n++;
            tick();
        end
        n_tests++;
        if (err !== 1'b1 || n != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got err=%b after %0d required 1 after %0d", err, n, TIMEOUT);
        end
        n_tests++;
        if (cpu_done !== 1'b1 || cpu_rdata !== model_cpu_rdata) begin
            n_fail++;
            $display("FAIL timeout_done: got done=%b rdata=%h required 1 %h", cpu_done, cpu_rdata, model_cpu_rdata);
        end
        ack_en = 1'b1;
        tick();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: got %b required 0", err);
        end
        wait_idle();
        cpu_word = 16'($urandom);
        cpu_req = 1'b1;
        n = 0;
        while (!cpu_gnt && n < 50) begin
            n++;
            tick();
        end
        n_tests++;
        if (cpu_gnt !== 1'b1 || spi_in !== cpu_word) begin
            n_fail++;
            $display("FAIL after_timeout_gnt: got gnt=%b in=%h required 1 %h", cpu_gnt, spi_in, cpu_word);
        end
        cpu_req = 1'b0;
        n = 0;
        while (!cpu_done && n < 50) begin
            n++;
            tick();
        end
        model_cpu_rdata = last_miso;
        n_tests++;
        if (cpu_done !== 1'b1 || cpu_rdata !== model_cpu_rdata || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_timeout_done: got done=%b rdata=%h err=%b required 1 %h 0",
                     cpu_done, cpu_rdata, err, model_cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int n, d0;
        wait_idle();
        ack_en = 1'b0;
        cpu_word = 16'($urandom);
        cpu_req = 1'b1;
        n = 0;
        while (!cpu_gnt && n < 50) begin
            n++;
            tick();
        end
        cpu_req = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (spi_wi !== 1'b1) begin
            n_fail++;
            $display("FAIL midxfer_pre: got wi=%b required 1", spi_wi);
        end
        d0 = done_cnt;
        #2 nrst = 1'b0;
        #1;
        n_tests++;
        if (spi_wi !== 1'b0 || spi_delay !== 1'b1) begin
            n_fail++;
            $display("FAIL async_wi_drop: got wi=%b delay=%b required 0 1", spi_wi, spi_delay);
        end
        ack_en = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (done_cnt != d0 || cpu_rdata !== 8'h0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got dones=%0d rdata=%h init_done=%b required %0d 00 0",
                     done_cnt - d0 + d0, cpu_rdata, init_done, d0);
        end
        rise_q.delete();
        fall_q.delete();
        word_q.delete();
        model_last = P_DISP;
        model_cpu_rdata = '0;
        model_disp_rdata = '0;
    endtask

    task automatic test_disp_pending();
        int n;
        logic [15:0] w;
        w = 16'($urandom);
        disp_word = w;
        nrst = 1'b1;
        repeat (10) tick();
        disp_req = 1'b1;
        n = 0;
        while (!disp_gnt && n < 2000) begin
            n++;
            tick();
        end
        n_tests++;
        if (disp_gnt !== 1'b1 || init_done !== 1'b1 || spi_in !== w) begin
            n_fail++;
            $display("FAIL pending_gnt: got gnt=%b init_done=%b in=%h required 1 1 %h", disp_gnt, init_done, spi_in, w);
        end
        disp_req = 1'b0;
        model_last = P_DISP;
        n_tests++;
        if (word_q.size() != INIT_LEN + 1) begin
            n_fail++;
            $display("FAIL replay_count: got %0d required %0d", word_q.size(), INIT_LEN + 1);
        end
        for (int i = 0; i < word_q.size() && i < INIT_LEN; i++) begin
            n_tests++;
            if (word_q[i] !== exp_init[i]) begin
                n_fail++;
                $display("FAIL replay_word%0d: got %h required %h", i, word_q[i], exp_init[i]);
            end
        end
        n = 0;
        while (!disp_done && n < 50) begin
            n++;
            tick();
        end
        model_disp_rdata = last_miso;
        n_tests++;
        if (disp_done !== 1'b1 || disp_rdata !== model_disp_rdata) begin
            n_fail++;
            $display("FAIL pending_done: got done=%b rdata=%h required 1 %h", disp_done, disp_rdata, model_disp_rdata);
        end
    endtask

    task automatic test_random();
        int grants, got, exp, base;
        bit pc, pd;
        grants = 0;
        base = rise_q.size();
        pc = cpu_req;
        pd = disp_req;
        for (int t = 0; t < 8000 && grants < 24; t++) begin
            tick();
            if (cpu_gnt || disp_gnt) begin
                got = cpu_gnt ? P_CPU : P_DISP;
                if (pc && pd) exp = (model_last == P_CPU) ? P_DISP : P_CPU;
                else if (pc) exp = P_CPU;
                else if (pd) exp = P_DISP;
                else exp = -1;
                n_tests++;
                if (got != exp || (cpu_gnt && disp_gnt)) begin
                    n_fail++;
                    $display("FAIL rand_winner: got %0d (gnt %b%b) required %0d", got, cpu_gnt, disp_gnt, exp);
                end
                n_tests++;
                if (spi_in !== ((got == P_CPU) ? cpu_word : disp_word)) begin
                    n_fail++;
                    $display("FAIL rand_word: got %h required %h", spi_in, (got == P_CPU) ? cpu_word : disp_word);
                end
                model_last = got;
                grants++;
                if (got == P_CPU) cpu_req = 1'b0;
                else disp_req = 1'b0;
            end
            if (cpu_done || disp_done) begin
                if (cpu_done) model_cpu_rdata = last_miso;
                else model_disp_rdata = last_miso;
                n_tests++;
                if (cpu_rdata !== model_cpu_rdata || disp_rdata !== model_disp_rdata || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_rdata: got %h/%h err=%b required %h/%h 0", cpu_rdata, disp_rdata, err,
                             model_cpu_rdata, model_disp_rdata);
                end
            end
            if (!cpu_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_word = 16'($urandom);
                    cpu_req = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 1'b0;
            end
            if (!disp_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    disp_word = 16'($urandom);
                    disp_req = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                disp_req = 1'b0;
            end
            pc = cpu_req;
            pd = disp_req;
        end
        cpu_req = 1'b0;
        disp_req = 1'b0;
        n_tests++;
        if (grants != 24) begin
            n_fail++;
            $display("FAIL rand_grants: got %0d required 24", grants);
        end
        for (int i = base + 1; i < rise_q.size() && i <= fall_q.size(); i++) begin
            n_tests++;
            if (rise_q[i] - fall_q[i-1] < GAP_CYCLES + 1) begin
                n_fail++;
                $display("FAIL rand_gap%0d: got %0d required >= %0d", i, rise_q[i] - fall_q[i-1], GAP_CYCLES + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_cpu_single();
        test_timeout();
        test_random();
        test_reset_mid_xfer();
        test_disp_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
